branch_predict_resolve: RTL

Branch prediction and resolution unit for the pipelined RV32I core. It holds a bimodal branch history table (BHT) of 2-bit saturating counters, which it reads in IF to supply a taken/not-taken prediction. In EX it drives BrUn into the branch comparator and consumes BrEq/BrLT to resolve the actual outcome. On a mispredict or jump it issues the redirect/flush, trains the BHT, and maintains branch/mispredict performance counters.

---
 rtl/branch_predict_resolve_pkg.sv | 33 +++
 rtl/bht_2bit.sv | 33 +++
 rtl/branch_predict_resolve.sv | 101 ++++++++++
 3 files changed

// File: rtl/branch_predict_resolve_pkg.sv
// Shared definitions for the branch predictor/resolver: branch funct3 codes,
// 2-bit counter encodings and the saturating counter step.
package branch_predict_resolve_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = CTR_WNT;

  // One training step of a 2-bit counter, saturating at both ends.
  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    if (taken && (c != CTR_ST)) begin
      n = ctr_e'(2'(c + 2'd1));
    end else if (!taken && (c != CTR_SNT)) begin
      n = ctr_e'(2'(c - 2'd1));
    end
    return n;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Bimodal history table: array of 2-bit saturating counters with one
// combinational read port and one training write port.
module bht_2bit
  import branch_predict_resolve_pkg::*;
#(
  parameter  int unsigned ENTRIES = 64,
  localparam int unsigned IDX     = $clog2(ENTRIES)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [IDX-1:0] rd_idx_i,
  output logic           rd_taken_o,
  input  logic [IDX-1:0] wr_idx_i,
  input  logic           wr_taken_i,
  input  logic           wr_en_i
);

  ctr_e cnt_q [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= CTR_RESET;
      end
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= ctr_next(cnt_q[wr_idx_i], wr_taken_i);
    end
  end

  // Reads see the registered array only, so a same-cycle write is not bypassed.
  assign rd_taken_o = cnt_q[rd_idx_i][1];

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch predict/resolve unit: IF-stage BHT lookup, EX-stage outcome decode,
// redirect generation, BHT training and branch/mispredict counters.
module branch_predict_resolve
  import branch_predict_resolve_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic        BrEq,
  input  logic        BrLT,
  output logic        BrUn,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt
);

  localparam int unsigned IDX = $clog2(BHT_ENTRIES);

  logic        fire;
  logic        legal;
  logic        taken;
  logic        br_fire;
  logic        jmp_fire;
  logic        mispredict;
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;
  logic        unused_pc_bits;

  assign unused_pc_bits = ^{if_pc[31:IDX+2], if_pc[1:0]};

  // Branch outcome from comparator flags; 010/011 decode as illegal.
  always_comb begin
    legal = 1'b1;
    taken = 1'b0;
    unique case (ex_funct3)
      F3_BEQ:          taken = BrEq;
      F3_BNE:          taken = !BrEq;
      F3_BLT, F3_BLTU: taken = BrLT;
      F3_BGE, F3_BGEU: taken = !BrLT;
      default:         legal = 1'b0;
    endcase
  end

  assign fire       = ex_valid & ~ex_stall & (ex_is_branch | ex_is_jump);
  assign jmp_fire   = fire & ex_is_jump;
  assign br_fire    = fire & ~ex_is_jump & ex_is_branch & legal;
  assign mispredict = br_fire & (taken ^ ex_pred_taken);

  assign BrUn        = ex_funct3[1];
  assign redirect    = jmp_fire | mispredict;
  assign redirect_pc = (mispredict & ~taken) ? (ex_pc + 32'd4) : ex_target;

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (br_fire) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (mispredict) begin
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

  bht_2bit #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (if_pc[IDX+1:2]),
    .rd_taken_o (if_pred_taken),
    .wr_idx_i   (ex_pc[IDX+1:2]),
    .wr_taken_i (taken),
    .wr_en_i    (br_fire)
  );

endmodule
